// File: rtl/beam_readout_pkg.sv
// rtl/beam_readout_pkg.sv - shared state encoding and default constants for beam_readout_streamer
package beam_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] HEADER_MAGIC = 16'hBEAF;

  localparam int DEF_NUM_POINTS   = 540;
  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int BEAT_W           = 10;

endpackage

// File: rtl/beam_readout_fifo.sv
// rtl/beam_readout_fifo.sv - skid FIFO for stream samples with sof/eof side bits and occupancy
module beam_readout_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_sof,
  input  logic                       wr_eof,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_sof,
  output logic                       rd_eof,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W+1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign do_wr = wr_en && (count != CW'(DEPTH));
  assign do_rd = rd_en && (count != '0);

  // Storage is unreset; entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {wr_sof, wr_eof, wr_data};
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // An empty FIFO presents zeros so idle stream outputs read as 0.
  assign {rd_sof, rd_eof, rd_data} = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/beam_readout_streamer.sv
// rtl/beam_readout_streamer.sv - result RAM frame readout to ready/valid stream; header beat under BEAM_READOUT_HEADER_EN
module beam_readout_streamer
  import beam_readout_pkg::*;
#(
  parameter int NUM_POINTS   = DEF_NUM_POINTS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beamformdone,
  output logic [ADDR_W-1:0] sumout_address,
  output logic              sumouten,
  input  logic [DATA_W-1:0] output_value,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eof,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef BEAM_READOUT_HEADER_EN
  localparam int FRAME_BEATS = NUM_POINTS + 1;
`else
  localparam int FRAME_BEATS = NUM_POINTS;
`endif

  state_t                  state;
  state_t                  state_nxt;
  logic                    bf_q;
  logic                    trigger;
  logic [ADDR_W-1:0]       addr_cnt;
  logic [READ_LATENCY-1:0] inflight_sr;
  logic [7:0]              inflight_cnt;
  logic [7:0]              level;
  logic                    issue;
  logic [BEAT_W-1:0]       wr_beat;
  logic                    hdr_wr;
  logic                    fifo_wr;
  logic                    fifo_rd;
  logic [DATA_W-1:0]       fifo_wdata;
  logic [CNT_W-1:0]        fifo_count;

  assign trigger = beamformdone && !bf_q;

`ifdef BEAM_READOUT_HEADER_EN
  logic [15:0] frame_count;

  // Frame counter stamped into the header; advances once per completed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_count <= '0;
    else if (state == ST_DONE) frame_count <= frame_count + 16'd1;
  end

  // The header goes in on the trigger edge, while the FIFO is known empty.
  assign hdr_wr     = (state == ST_IDLE) && trigger;
  assign fifo_wdata = hdr_wr ? DATA_W'({HEADER_MAGIC, frame_count}) : output_value;
`else
  assign hdr_wr     = 1'b0;
  assign fifo_wdata = output_value;
`endif

  assign fifo_wr = hdr_wr || inflight_sr[READ_LATENCY-1];
  assign m_valid = (fifo_count != '0);
  assign fifo_rd = m_valid && m_ready;

  // Count reads issued but not yet returned by the RAM.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight_cnt = inflight_cnt + 8'(inflight_sr[i]);
  end

  assign level = 8'(fifo_count) + inflight_cnt;

  // Next state; reads are only issued while FIFO plus in-flight reads leave room.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        busy  = 1'b1;
        issue = (level < 8'(FIFO_DEPTH));
        if (issue && (addr_cnt == ADDR_W'(NUM_POINTS - 1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if ((fifo_count == '0) && (inflight_cnt == '0)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign sumouten       = issue;
  assign sumout_address = addr_cnt;

  // State, trigger edge register, read address and write-side beat index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bf_q     <= 1'b0;
      addr_cnt <= '0;
      wr_beat  <= '0;
    end else begin
      state <= state_nxt;
      bf_q  <= beamformdone;
      if (state == ST_DONE) addr_cnt <= '0;
      else if (issue)       addr_cnt <= addr_cnt + ADDR_W'(1);
      if (state == ST_DONE) wr_beat <= '0;
      else if (fifo_wr)     wr_beat <= wr_beat + BEAT_W'(1);
    end
  end

  // Issue flags ride alongside the RAM pipeline to mark returning data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_sr <= '0;
    end else begin
      inflight_sr[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) inflight_sr[i] <= inflight_sr[i-1];
    end
  end

  beam_readout_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .wr_sof  (wr_beat == '0),
    .wr_eof  (wr_beat == BEAT_W'(FRAME_BEATS - 1)),
    .rd_en   (fifo_rd),
    .rd_data (m_data),
    .rd_sof  (m_sof),
    .rd_eof  (m_eof),
    .count   (fifo_count)
  );

endmodule

// File: doc/beam_readout_streamer.md
# beam_readout_streamer

Reads a completed beamformed frame out of the beamformer's result RAM (540 signed 32-bit sums) and presents it as a ready/valid word stream for downstream transport (UART bridge, DMA, host link). It sits on the read side of the result RAM: it drives `sumout_address`/`sumouten`, absorbs the RAM read latency, and tolerates arbitrary backpressure without dropping or duplicating samples. A frame transfer starts on the rising edge of the beamformer's `beamformdone` flag.

## Interface
- `NUM_POINTS`, 540: result words per frame.
- `ADDR_W`, 10: result RAM address width.
- `DATA_W`, 32: sample width (signed).
- `READ_LATENCY`, 1: cycles from address/rden to valid `output_value`.
- `FIFO_DEPTH`, 4: skid FIFO entries; must be ≥ READ_LATENCY+2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `beamformdone`  in  1  level flag from beamformer; rising edge triggers a frame.
- `sumout_address`  out  ADDR_W  result RAM read address.
- `sumouten`  out  1  result RAM read enable.
- `output_value`  in  DATA_W  signed RAM read data.
- `m_data`  out  DATA_W  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_sof`  out  1  first beat of frame (qualified by `m_valid`).
- `m_eof`  out  1  last beat of frame.
- `busy`  out  1  high from trigger until last beat accepted.
- `frame_done`  out  1  one-cycle pulse after last beat accepted.

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: `beamformdone` registered; trigger = current high and previous low. Trigger → STREAM, address counter = 0, `busy`=1.
- STREAM: each cycle issue a read (`sumouten`=1, `sumout_address`=counter) iff FIFO occupancy + in-flight reads < FIFO_DEPTH. Counter increments per issue. After issuing address NUM_POINTS-1 → DRAIN.
- In-flight tracking: READ_LATENCY-deep shift register of issue flags; when flag exits, `output_value` written into FIFO.
- DRAIN: no reads; wait until FIFO empty and nothing in flight after final handshake → DONE.
- DONE: `frame_done`=1 for one cycle, `busy`=0, → IDLE.
- Stream: `m_valid` = FIFO not empty; beat transfers when `m_valid && m_ready`; `m_data` stable while `m_valid && !m_ready`.
- `m_sof` on beat index 0, `m_eof` on beat index NUM_POINTS-1 (header shifts indexing, see Configuration). Beat counter 10 bits, independent of address counter.
- Trigger while not IDLE ignored (edge detector still updates, so a held-high flag does not retrigger on return to IDLE).
- Data passed unmodified; no sign extension or truncation.

## Timing
- Reset values: `sumout_address`=0, `sumouten`=0, `m_valid`=0, `m_sof`=0, `m_eof`=0, `busy`=0, `frame_done`=0, FIFO empty, state IDLE, edge register 0.
- Trigger edge seen in cycle T → first `sumouten` in T+1; first `m_valid` at T+1+READ_LATENCY+1 (FIFO write then registered output).
- With `m_ready` held high: one beat per cycle sustained; frame of 540 beats completes in 540 + READ_LATENCY + 3 cycles from trigger.
- `m_ready` low indefinitely: reads stall once FIFO+in-flight = FIFO_DEPTH; no overflow, no loss.
- Reset mid-frame: asynchronous clear; `sumouten` and `m_valid` drop immediately; partial frame abandoned; next trigger restarts at address 0.
- `beamformdone` already high when reset releases: edge register starts 0 → triggers in first cycle after reset.

## Configuration
- `BEAM_READOUT_HEADER_EN` defined: one header beat precedes samples, `m_data` = {16'hBEAF, frame_count[15:0]}; `m_sof` on header, frame = NUM_POINTS+1 beats; frame_count increments on `frame_done`, wraps 0xFFFF→0, reset 0.
- Undefined: no header, no frame counter; `m_sof` on sample 0, frame = NUM_POINTS beats.

## Structure
- Package `beam_readout_pkg`: state encoding, header magic 16'hBEAF, default NUM_POINTS/ADDR_W/DATA_W constants.
- Sub-module `beam_readout_fifo`: synchronous FIFO, FIFO_DEPTH×DATA_W plus sof/eof side bits, occupancy output, registered read data.

## Test plan
- Reset, RAM preloaded with value=address, raise `beamformdone`, `m_ready`=1 → 540 beats 0..539 in order, `m_sof` on 0, `m_eof` on 539, one `frame_done`.
- `m_ready` random 30% duty → identical sequence, no gaps/duplicates, `sumouten` asserted exactly 540 times.
- `m_ready` held low 100 cycles mid-frame → at most FIFO_DEPTH reads outstanding, `m_data` stable, resumes with next value.
- Negative data (0x80000000, 0xFFFFFFFF at addresses 0,1) → emitted bit-exact.
- Pulse `beamformdone` again mid-frame → ignored; toggle low/high after `frame_done` → second frame; with HEADER_EN headers read 0xBEAF0000 then 0xBEAF0001.
- Assert `rst` low at beat 200 → all outputs 0 asynchronously; new trigger restarts from address 0.
